// File: rtl/bound_flasher_gen_if.sv
`default_nettype none
// ============================================================================
// Module  : bound_flasher_gen_if
// Purpose : Control/status bundle of the bound flasher (hold only with FLASHER_HOLD_EN)
// Rev     : 1.0
// ============================================================================
interface bound_flasher_gen_if #(
    parameter int N_LED   = 16,
    parameter int N_PHASE = 6,
    parameter int LW      = $clog2(N_LED + 1),
    parameter int PW      = $clog2(N_PHASE)
);
    logic                    flick;
    logic [N_PHASE*LW-1:0]   phase_bound;
    logic [N_LED:0]          kick_mask;
`ifdef FLASHER_HOLD_EN
    logic                    hold;
`endif
    logic [N_LED-1:0]        led;
    logic [1:0]              state;
    logic [PW-1:0]           phase;
    logic                    done;

    modport master (
`ifdef FLASHER_HOLD_EN
        output hold,
`endif
        output flick, phase_bound, kick_mask,
        input  led, state, phase, done
    );

    modport slave (
`ifdef FLASHER_HOLD_EN
        input  hold,
`endif
        input  flick, phase_bound, kick_mask,
        output led, state, phase, done
    );
endinterface
`default_nettype wire

// File: rtl/bound_flasher_gen.sv
`default_nettype none
// ============================================================================
// Module  : bound_flasher_gen
// Purpose : N_LED thermometer flasher, programmable climb/descend phases with
//           kick-back on flick edges. Optional freeze input via FLASHER_HOLD_EN.
// Rev     : 1.0
// ============================================================================
module bound_flasher_gen #(
    parameter int N_LED   = 16,
    parameter int N_PHASE = 6,
    parameter int LW      = $clog2(N_LED + 1),
    parameter int PW      = $clog2(N_PHASE)
) (
    input  wire logic           clk,
    input  wire logic           reset,
    bound_flasher_gen_if.slave  io_bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_UP   = 2'b01,
        S_DOWN = 2'b10,
        S_BAD  = 2'b11
    } state_t;

    localparam logic [LW-1:0] C_LVL_MAX  = LW'(N_LED);
    localparam logic [PW-1:0] C_LAST_PH  = PW'(N_PHASE - 1);

    state_t          r_state;
    logic [PW-1:0]   r_phase;
    logic [LW-1:0]   r_level;
    logic            r_done;
    logic            r_flick_q;

    logic [LW-1:0]   w_bounds [N_PHASE];
    logic [LW-1:0]   w_bound;
    logic [LW-1:0]   w_lvl_inc;
    logic [LW-1:0]   w_lvl_dec;
    logic            w_flick_rise;
    logic            w_kick;
    logic            w_hold;

    // Out-of-range bounds clamp to the full bar
    for (genvar p = 0; p < N_PHASE; p++) begin : g_bound
        assign w_bounds[p] = (io_bus.phase_bound[p*LW +: LW] > C_LVL_MAX) ?
                             C_LVL_MAX : io_bus.phase_bound[p*LW +: LW];
    end

    assign w_bound      = w_bounds[r_phase];
    assign w_lvl_inc    = (r_level == C_LVL_MAX) ? r_level : r_level + LW'(1);
    assign w_lvl_dec    = (r_level == '0) ? r_level : r_level - LW'(1);
    assign w_flick_rise = io_bus.flick & ~r_flick_q;
    assign w_kick       = w_flick_rise & io_bus.kick_mask[r_level];

`ifdef FLASHER_HOLD_EN
    assign w_hold = io_bus.hold;
`else
    assign w_hold = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_phase   <= '0;
            r_level   <= '0;
            r_done    <= 1'b0;
            r_flick_q <= 1'b0;
        end else begin
            // Edge history keeps tracking during hold so a held-over edge is not replayed
            r_flick_q <= io_bus.flick;
            r_done    <= 1'b0;
            if (!w_hold) begin
                case (r_state)
                    S_IDLE: begin
                        if (io_bus.flick) begin
                            r_state <= S_UP;
                            r_phase <= '0;
                            r_level <= LW'(1);
                        end
                    end
                    S_UP: begin
                        if (r_level < w_bound) begin
                            r_level <= w_lvl_inc;
                        end else begin
                            r_state <= S_DOWN;
                            r_phase <= r_phase + PW'(1);
                        end
                    end
                    S_DOWN: begin
                        if (w_kick) begin
                            r_state <= S_UP;
                            r_phase <= r_phase - PW'(1);
                            r_level <= w_lvl_inc;
                        end else if (r_level > w_bound) begin
                            r_level <= w_lvl_dec;
                        end else if (r_phase == C_LAST_PH) begin
                            r_state <= S_IDLE;
                            r_phase <= '0;
                            r_level <= '0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_UP;
                            r_phase <= r_phase + PW'(1);
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_phase <= '0;
                        r_level <= '0;
                    end
                endcase
            end
        end
    end

    for (genvar i = 0; i < N_LED; i++) begin : g_led
        assign io_bus.led[i] = (r_level > LW'(i));
    end

    assign io_bus.state = r_state;
    assign io_bus.phase = r_phase;
    assign io_bus.done  = r_done;
endmodule
`default_nettype wire

// File: tb/tb_bound_flasher_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_bound_flasher_gen
// Purpose : Directed self-checking bench for bound_flasher_gen (16 LEDs, 6 phases)
// Rev     : 1.0
// ============================================================================
module tb_bound_flasher_gen;
    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    bound_flasher_gen_if #(.N_LED(16), .N_PHASE(6)) bus ();

    bound_flasher_gen #(.N_LED(16), .N_PHASE(6)) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bounds(input int b0, input int b1, input int b2,
                              input int b3, input int b4, input int b5);
        bus.phase_bound = {5'(b5), 5'(b4), 5'(b3), 5'(b2), 5'(b1), 5'(b0)};
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.flick = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic start_seq();
        bus.flick = 1'b1;
        tick();
        bus.flick = 1'b0;
    endtask

    task automatic test_reset();
        int done_seen = 0;
        bit bad = 0;
        reset = 1'b0;
        #3;
        checks++; if (bus.led !== 16'h0) begin errors++; $display("FAIL rst_led got=%h exp=0000", bus.led); end
        checks++; if (bus.state !== 2'b00) begin errors++; $display("FAIL rst_state got=%b exp=00", bus.state); end
        checks++; if (bus.phase !== 3'd0) begin errors++; $display("FAIL rst_phase got=%0d exp=0", bus.phase); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", bus.done); end
        tick();
        reset = 1'b1;
        repeat (20) begin
            tick();
            if (bus.done === 1'b1) done_seen++;
            if (bus.state !== 2'b00 || bus.led !== 16'h0 || bus.phase !== 3'd0) bad = 1;
        end
        checks++; if (bad) begin errors++; $display("FAIL idle_hold got=left_idle exp=idle"); end
        checks++; if (done_seen !== 0) begin errors++; $display("FAIL idle_done got=%0d exp=0", done_seen); end
    endtask

    task automatic test_sequence();
        int done_cnt = 0;
        do_reset();
        set_bounds(16, 6, 11, 0, 6, 0);
        bus.kick_mask = 17'h0;
        start_seq();
        checks++; if (bus.state !== 2'b01 || bus.led !== 16'h0001) begin errors++;
            $display("FAIL seq_start got=%b/%h exp=01/0001", bus.state, bus.led); end
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (bus.done === 1'b1) done_cnt++;
            case (k)
                15: begin checks++; if (bus.led !== 16'hFFFF || bus.state !== 2'b01) begin errors++;
                        $display("FAIL seq_peak got=%h/%b exp=ffff/01", bus.led, bus.state); end end
                16: begin checks++; if (bus.state !== 2'b10 || bus.phase !== 3'd1) begin errors++;
                        $display("FAIL seq_p1 got=%b/%0d exp=10/1", bus.state, bus.phase); end end
                26: begin checks++; if (bus.led !== 16'h003F || bus.state !== 2'b10) begin errors++;
                        $display("FAIL seq_low1 got=%h/%b exp=003f/10", bus.led, bus.state); end end
                27: begin checks++; if (bus.state !== 2'b01 || bus.phase !== 3'd2 || bus.led !== 16'h003F) begin errors++;
                        $display("FAIL seq_p2 got=%b/%0d/%h exp=01/2/003f", bus.state, bus.phase, bus.led); end end
                32: begin checks++; if (bus.led !== 16'h07FF) begin errors++;
                        $display("FAIL seq_peak2 got=%h exp=07ff", bus.led); end end
                33: begin checks++; if (bus.state !== 2'b10 || bus.phase !== 3'd3) begin errors++;
                        $display("FAIL seq_p3 got=%b/%0d exp=10/3", bus.state, bus.phase); end end
                58: begin checks++; if (bus.state !== 2'b10 || bus.phase !== 3'd5 || bus.led !== 16'h0 || bus.done !== 1'b0) begin errors++;
                        $display("FAIL seq_p5 got=%b/%0d/%h/%b exp=10/5/0000/0", bus.state, bus.phase, bus.led, bus.done); end end
                59: begin checks++; if (bus.done !== 1'b1 || bus.state !== 2'b00 || bus.led !== 16'h0) begin errors++;
                        $display("FAIL seq_done got=%b/%b/%h exp=1/00/0000", bus.done, bus.state, bus.led); end end
                60: begin checks++; if (bus.done !== 1'b0 || bus.state !== 2'b00) begin errors++;
                        $display("FAIL seq_after got=%b/%b exp=0/00", bus.done, bus.state); end end
                default: ;
            endcase
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL seq_done_cnt got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_kick();
        do_reset();
        set_bounds(16, 6, 11, 0, 6, 0);
        bus.kick_mask = 17'h00040;
        start_seq();
        repeat (26) tick();
        checks++; if (bus.led !== 16'h003F || bus.state !== 2'b10 || bus.phase !== 3'd1) begin errors++;
            $display("FAIL kick_pre got=%h/%b/%0d exp=003f/10/1", bus.led, bus.state, bus.phase); end
        bus.flick = 1'b1;
        tick();
        checks++; if (bus.state !== 2'b01 || bus.phase !== 3'd0 || bus.led !== 16'h007F) begin errors++;
            $display("FAIL kick_go got=%b/%0d/%h exp=01/0/007f", bus.state, bus.phase, bus.led); end
        bus.flick = 1'b0;
        repeat (9) tick();
        checks++; if (bus.led !== 16'hFFFF || bus.state !== 2'b01) begin errors++;
            $display("FAIL kick_climb got=%h/%b exp=ffff/01", bus.led, bus.state); end
        tick();
        checks++; if (bus.state !== 2'b10 || bus.phase !== 3'd1) begin errors++;
            $display("FAIL kick_redesc got=%b/%0d exp=10/1", bus.state, bus.phase); end
    endtask

    task automatic test_flick_held();
        do_reset();
        set_bounds(16, 6, 11, 0, 6, 0);
        bus.kick_mask = 17'h00100;
        start_seq();
        repeat (23) tick();
        checks++; if (bus.led !== 16'h01FF) begin errors++; $display("FAIL held_pre got=%h exp=01ff", bus.led); end
        bus.flick = 1'b1;
        tick();
        checks++; if (bus.led !== 16'h00FF || bus.state !== 2'b10) begin errors++;
            $display("FAIL held_unmasked got=%h/%b exp=00ff/10", bus.led, bus.state); end
        tick();
        checks++; if (bus.led !== 16'h007F || bus.state !== 2'b10) begin errors++;
            $display("FAIL held_norise got=%h/%b exp=007f/10", bus.led, bus.state); end
        tick();
        tick();
        checks++; if (bus.state !== 2'b01 || bus.phase !== 3'd2) begin errors++;
            $display("FAIL held_p2 got=%b/%0d exp=01/2", bus.state, bus.phase); end
        bus.flick = 1'b0;
    endtask

    task automatic test_kick_sat();
        do_reset();
        set_bounds(16, 6, 11, 0, 6, 0);
        bus.kick_mask = 17'h10000;
        start_seq();
        repeat (16) tick();
        bus.flick = 1'b1;
        tick();
        checks++; if (bus.state !== 2'b01 || bus.phase !== 3'd0 || bus.led !== 16'hFFFF) begin errors++;
            $display("FAIL ksat_go got=%b/%0d/%h exp=01/0/ffff", bus.state, bus.phase, bus.led); end
        tick();
        checks++; if (bus.state !== 2'b10 || bus.phase !== 3'd1) begin errors++;
            $display("FAIL ksat_desc got=%b/%0d exp=10/1", bus.state, bus.phase); end
        tick();
        checks++; if (bus.led !== 16'h7FFF) begin errors++; $display("FAIL ksat_step got=%h exp=7fff", bus.led); end
        bus.flick = 1'b0;
    endtask

    task automatic test_bound_sat();
        do_reset();
        set_bounds(31, 0, 0, 0, 0, 0);
        bus.kick_mask = 17'h0;
        start_seq();
        repeat (16) tick();
        checks++; if (bus.state !== 2'b10 || bus.phase !== 3'd1 || bus.led !== 16'hFFFF) begin errors++;
            $display("FAIL bsat got=%b/%0d/%h exp=10/1/ffff", bus.state, bus.phase, bus.led); end
    endtask

    task automatic test_reset_mid();
        bit bad = 0;
        do_reset();
        set_bounds(16, 6, 11, 0, 6, 0);
        start_seq();
        repeat (8) tick();
        checks++; if (bus.led !== 16'h01FF) begin errors++; $display("FAIL rmid_pre got=%h exp=01ff", bus.led); end
        reset = 1'b0;
        #2;
        checks++; if (bus.led !== 16'h0 || bus.state !== 2'b00 || bus.phase !== 3'd0) begin errors++;
            $display("FAIL rmid_async got=%h/%b/%0d exp=0000/00/0", bus.led, bus.state, bus.phase); end
        tick();
        reset = 1'b1;
        repeat (5) begin
            tick();
            if (bus.state !== 2'b00 || bus.led !== 16'h0) bad = 1;
        end
        checks++; if (bad) begin errors++; $display("FAIL rmid_idle got=left_idle exp=idle"); end
        start_seq();
        checks++; if (bus.state !== 2'b01 || bus.led !== 16'h0001) begin errors++;
            $display("FAIL rmid_restart got=%b/%h exp=01/0001", bus.state, bus.led); end
    endtask

`ifdef FLASHER_HOLD_EN
    task automatic test_hold();
        bit bad = 0;
        do_reset();
        set_bounds(16, 6, 11, 0, 6, 0);
        bus.kick_mask = 17'h0;
        start_seq();
        repeat (11) tick();
        checks++; if (bus.led !== 16'h0FFF) begin errors++; $display("FAIL hold_pre got=%h exp=0fff", bus.led); end
        bus.hold = 1'b1;
        repeat (10) begin
            tick();
            if (bus.led !== 16'h0FFF || bus.state !== 2'b01) bad = 1;
        end
        checks++; if (bad) begin errors++; $display("FAIL hold_freeze got=moved exp=0fff"); end
        bus.hold = 1'b0;
        tick();
        checks++; if (bus.led !== 16'h1FFF) begin errors++; $display("FAIL hold_rel1 got=%h exp=1fff", bus.led); end
        tick();
        checks++; if (bus.led !== 16'h3FFF) begin errors++; $display("FAIL hold_rel2 got=%h exp=3fff", bus.led); end
    endtask
`endif

    initial begin
        clk = 1'b0;
        reset = 1'b0;
        bus.flick = 1'b0;
        bus.kick_mask = 17'h0;
`ifdef FLASHER_HOLD_EN
        bus.hold = 1'b0;
`endif
        set_bounds(16, 6, 11, 0, 6, 0);
        test_reset();
        test_sequence();
        test_kick();
        test_flick_held();
        test_kick_sat();
        test_bound_sat();
        test_reset_mid();
`ifdef FLASHER_HOLD_EN
        test_hold();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/bound_flasher_gen.md
Name: bound_flasher_gen

Overview:
Parametrised successor of the team's 16-LED bound flasher. Drives an N_LED thermometer bar through a programmable sequence of alternating climb/descend phases, with bounds supplied per phase on a port bus rather than hard-coded. Fully synchronous: `flick` is sampled on `clk` and edge-detected, and is never used as a clock. Sits between the board push-button synchroniser and the LED pad drivers.

Parameters:
N_LED, 16, number of LEDs; bar level range 0..N_LED
N_PHASE, 6, phases per sequence; must be even and >=2; even index = climb, odd index = descend
LW, $clog2(N_LED+1), level/bound width (derived)
PW, $clog2(N_PHASE), phase index width (derived)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
flick  input  1  start/kick request, synchronous to clk
phase_bound  input  N_PHASE*LW  bound of phase p at [p*LW +: LW]; quasi-static
kick_mask  input  N_LED+1  bit k=1 makes level k a kick point during descend phases
led  output  N_LED  thermometer bar; led[i]=1 iff i < level
state  output  2  00 IDLE, 01 GO_UP, 10 GO_DOWN
phase  output  PW  current phase index
done  output  1  one-cycle pulse on the cycle IDLE is re-entered from a completed sequence

Behaviour:
- Reset (reset=0, async): level=0, led=0, state=IDLE, phase=0, done=0, flick_q=0.
- Registered outputs; led is a function of the level register only.
- flick_q <= flick every cycle; flick_rise = flick & ~flick_q.
- Bounds greater than N_LED saturate to N_LED.
- IDLE: flick=1 (level-sensitive) at a clock edge -> GO_UP, phase=0, level=1. Otherwise hold.
- GO_UP, phase p:
  - level < bound(p): level+1 per cycle.
  - level >= bound(p): one dwell cycle with level held, then state=GO_DOWN, phase=p+1.
  - flick is ignored.
- GO_DOWN, phase p:
  - Kick: flick_rise and kick_mask[level] -> state=GO_UP, phase=p-1, level=level+1 (saturating at N_LED). Kick has priority over the normal step.
  - Else level > bound(p): level-1 per cycle.
  - Else (level <= bound(p)), dwell:
    - If p==N_PHASE-1: state=IDLE, phase=0, level=0, done=1 for one cycle.
    - Otherwise: state=GO_UP, phase=p+1, level held.
- Level arithmetic never wraps: no increment above N_LED, no decrement below 0.
- Reset asserted mid-sequence aborts immediately to the reset values. After release, the block idles until flick is high.
- phase_bound or kick_mask changing mid-sequence takes effect on the next clock.
- state 11 is unreachable; if entered, the next cycle goes to IDLE with level=0.

Optional Feature:
Macro FLASHER_HOLD_EN.
- Defined: adds input port `hold` (1 bit).
  - While hold=1: level, state and phase freeze, flick and kicks are ignored, done stays 0.
  - flick_q still updates, so a flick edge that occurs during hold is not replayed on release.
- Undefined: no hold port; behaviour exactly as above.

Test Plan:
- Reset then release with flick=0 for 20 cycles -> led=0, state=IDLE, phase=0, done never set.
- Bounds {16,6,11,0,6,0}, one flick pulse -> led peaks 0xFFFF in phase 0, descends to 0x003F in phase 1, reaches 0x07FF in phase 2. done pulses exactly 59 clocks after the start edge, then state=IDLE, led=0.
- kick_mask bit 6 set; flick rising edge when level=6 in phase 1 -> next cycle state=GO_UP, phase=0, level=7, climb resumes to 16.
- flick held high through a descend phase -> only the first rising edge can kick. A kick at a non-masked level (e.g. level 9) is ignored and descent continues.
- Reset asserted mid-climb at level 9 -> led=0 and state=IDLE asynchronously. After release, the sequence restarts only on flick.
- With FLASHER_HOLD_EN: hold=1 for 10 cycles at level 12 -> led stays 0x0FFF. On release, the climb continues at one step per cycle.
